// File: rtl/vram_pkg.sv
// Shared types for the VRAM write scheduler.
//   VramWindowSize : size of the CPU-visible VRAM window (4 KiB)
//   sched_state_e  : scheduler FSM states
//   vram_entry_t   : one queued write (12-bit VRAM offset, 8-bit data)
package vram_pkg;

  localparam logic [15:0] VramWindowSize = 16'h1000;

  typedef enum logic [1:0] {
    StIdle,     // queue empty
    StBlocked,  // entries pending, drain not permitted
    StDrain     // issuing entries
  } sched_state_e;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } vram_entry_t;

endpackage

// File: rtl/vram_write_scheduler_if.sv
// CPU-side request, GPU arbitration and VRAM write port bundle for the scheduler.
//   slave  : scheduler view (takes requests/status, drives the VRAM write port and flags)
//   master : environment view (drives requests/status, observes the VRAM write port)
interface vram_write_scheduler_if;

  logic        wr_valid;
  logic [15:0] cpu_address;
  logic [7:0]  data_in;
  logic        gpu_busy;
  logic        vblank;
  logic        overflow_clear;
  logic        vram_we;
  logic [11:0] vram_address;
  logic [7:0]  vram_data;
  logic        queue_empty;
  logic        queue_full;
  logic        overflow;

  modport slave (
    input  wr_valid, cpu_address, data_in, gpu_busy, vblank, overflow_clear,
    output vram_we, vram_address, vram_data, queue_empty, queue_full, overflow
  );

  modport master (
    output wr_valid, cpu_address, data_in, gpu_busy, vblank, overflow_clear,
    input  vram_we, vram_address, vram_data, queue_empty, queue_full, overflow
  );

endinterface

// File: rtl/vram_write_fifo_m.sv
// Write queue for the VRAM scheduler: storage, wrapping pointers and occupancy.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (flushes the queue)
//   push/entry   : enqueue one entry (caller guarantees room)
//   pop          : dequeue the head (caller guarantees non-empty)
//   head         : current head entry (combinational read)
//   empty, full  : registered occupancy flags
//   count        : current occupancy
module vram_write_fifo_m
  import vram_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  vram_entry_t              push_entry,
  input  logic                     pop,
  output vram_entry_t              head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  vram_entry_t     mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            empty_q, full_q;

  always_comb begin
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CntW'(DEPTH));
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  assign head  = mem[rd_ptr_q];
  assign empty = empty_q;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/vram_write_scheduler_m.sv
// VRAM write scheduler: queues CPU writes that hit the VRAM window and issues them
// to the VRAM port, one per cycle, whenever the GPU does not own the port.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (flushes queue, clears flags and outputs)
//   bus  : vram_write_scheduler_if.slave (CPU request, gpu_busy/vblank, VRAM write port,
//          queue_empty/queue_full/overflow status)
// Build option: define VRAM_WRITE_SCHEDULER_VBLANK_ONLY_EN to restrict draining to
// vertical blanking (vblank=1 and gpu_busy=0); otherwise vblank is ignored.
module vram_write_scheduler_m
  import vram_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] VRAM_BASE = 16'h3000
) (
  input logic                    clk,
  input logic                    rst,
  vram_write_scheduler_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  sched_state_e    state_q, state_d;
  logic            permit, deq, enq, drop, req, in_window;
  logic [15:0]     offset;
  logic [CntW-1:0] fifo_count, occ_next;
  logic            fifo_empty, fifo_full;
  vram_entry_t     head, push_entry;

  logic        we_q;
  logic [11:0] addr_q;
  logic [7:0]  data_q;
  logic        overflow_q;

`ifdef VRAM_WRITE_SCHEDULER_VBLANK_ONLY_EN
  assign permit = bus.vblank && !bus.gpu_busy;
`else
  logic unused_vblank;
  assign unused_vblank = bus.vblank;
  assign permit = !bus.gpu_busy;
`endif

  // Wrapping subtraction: addresses below the base land far above the window.
  assign offset    = bus.cpu_address - VRAM_BASE;
  assign in_window = (offset < VramWindowSize);
  assign req       = bus.wr_valid && in_window;

  // StIdle tracks an empty queue, so this is "permitted and non-empty".
  assign deq  = permit && (state_q != StIdle);
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign enq  = req && (!fifo_full || deq);
  assign drop = req && fifo_full && !deq;

  assign push_entry.addr = offset[11:0];
  assign push_entry.data = bus.data_in;

  vram_write_fifo_m #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (enq),
    .push_entry (push_entry),
    .pop        (deq),
    .head       (head),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    occ_next = fifo_count + CntW'(enq) - CntW'(deq);
    case (state_q)
      StIdle: begin
        if (enq) state_d = permit ? StDrain : StBlocked;
      end
      StBlocked, StDrain: begin
        if (occ_next == '0) state_d = StIdle;
        else if (permit)    state_d = StDrain;
        else                state_d = StBlocked;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= deq;
      if (deq) begin
        addr_q <= head.addr;
        data_q <= head.data;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)                    overflow_q <= 1'b1;
      else if (bus.overflow_clear) overflow_q <= 1'b0;
    end
  end

  assign bus.vram_we      = we_q;
  assign bus.vram_address = addr_q;
  assign bus.vram_data    = data_q;
  assign bus.queue_empty  = fifo_empty;
  assign bus.queue_full   = fifo_full;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_vram_write_scheduler_m.sv
// Self-checking bench for vram_write_scheduler_m (DEPTH=8, VRAM_BASE=16'h3000).
// A vector table covers single-cycle behaviour; hand sequences cover overflow,
// full-with-drain, reset mid-drain and (when built with the vblank option) vblank gating.
module tb_vram_write_scheduler_m;

  logic clk;
  logic rst;
  vram_write_scheduler_if bus ();

  vram_write_scheduler_m #(
    .DEPTH     (8),
    .VRAM_BASE (16'h3000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        busy;
    logic        we;
    logic [11:0] va;
    logic [7:0]  vd;
    logic        empty;
    logic        full;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [15:0] a, input logic [7:0] d,
                       input logic busy);
    bus.wr_valid    = wr;
    bus.cpu_address = a;
    bus.data_in     = d;
    bus.gpu_busy    = busy;
  endtask

  task automatic add(input logic r, input logic wr, input logic [15:0] a, input logic [7:0] d,
                     input logic busy, input logic we, input logic [11:0] va,
                     input logic [7:0] vd, input logic e, input logic f, input logic o);
    vec_t v;
    v = '{r, wr, a, d, busy, we, va, vd, e, f, o};
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.overflow_clear = 1'b0;
    bus.vblank = 1'b1;
    drive(1'b0, 16'h0, 8'h0, 1'b0);

    //  rst wr  addr     data   busy | we  va       vd     empty full ov
    add(1, 0, 16'h0000, 8'h00, 0,     0, 12'h000, 8'h00, 1, 0, 0);
    add(0, 1, 16'h3700, 8'h99, 0,     0, 12'h000, 8'h00, 0, 0, 0);
    add(0, 0, 16'h0000, 8'h00, 0,     1, 12'h700, 8'h99, 1, 0, 0);
    add(0, 0, 16'h0000, 8'h00, 0,     0, 12'h700, 8'h99, 1, 0, 0);
    add(0, 1, 16'h7003, 8'h55, 0,     0, 12'h700, 8'h99, 1, 0, 0);
    add(0, 1, 16'h2FFF, 8'h11, 0,     0, 12'h700, 8'h99, 1, 0, 0);
    add(0, 1, 16'h3000, 8'h01, 1,     0, 12'h700, 8'h99, 0, 0, 0);
    add(0, 1, 16'h3FFF, 8'h02, 1,     0, 12'h700, 8'h99, 0, 0, 0);
    add(0, 1, 16'h4000, 8'h03, 1,     0, 12'h700, 8'h99, 0, 0, 0);
    add(0, 0, 16'h0000, 8'h00, 0,     1, 12'h000, 8'h01, 0, 0, 0);
    add(0, 0, 16'h0000, 8'h00, 0,     1, 12'hFFF, 8'h02, 1, 0, 0);
    add(0, 0, 16'h0000, 8'h00, 0,     0, 12'hFFF, 8'h02, 1, 0, 0);
    add(0, 1, 16'h3010, 8'hAA, 0,     0, 12'hFFF, 8'h02, 0, 0, 0);
    add(0, 1, 16'h3011, 8'hBB, 0,     1, 12'h010, 8'hAA, 0, 0, 0);
    add(0, 0, 16'h0000, 8'h00, 0,     1, 12'h011, 8'hBB, 1, 0, 0);
    add(0, 0, 16'h0000, 8'h00, 0,     0, 12'h011, 8'hBB, 1, 0, 0);
    add(1, 1, 16'h3020, 8'hCC, 0,     0, 12'h000, 8'h00, 1, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      drive(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].busy);
      tick();
      chk($sformatf("vec%0d we", i),    32'(bus.vram_we),      32'(vecs[i].we));
      chk($sformatf("vec%0d addr", i),  32'(bus.vram_address), 32'(vecs[i].va));
      chk($sformatf("vec%0d data", i),  32'(bus.vram_data),    32'(vecs[i].vd));
      chk($sformatf("vec%0d empty", i), 32'(bus.queue_empty),  32'(vecs[i].empty));
      chk($sformatf("vec%0d full", i),  32'(bus.queue_full),   32'(vecs[i].full));
      chk($sformatf("vec%0d ovf", i),   32'(bus.overflow),     32'(vecs[i].ov));
    end
    rst = 1'b0;
    drive(1'b0, 16'h0, 8'h0, 0);
    tick();

    // Overflow: 9 writes while blocked, set-wins-over-clear, then ordered drain.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 16'h3100 + 16'(i), 8'h10 + 8'(i), 1'b1);
      tick();
      if (i == 6) chk("ovfseq full@7", 32'(bus.queue_full), 32'd0);
      if (i == 7) begin
        chk("ovfseq full@8", 32'(bus.queue_full), 32'd1);
        chk("ovfseq ovf@8", 32'(bus.overflow), 32'd0);
      end
    end
    chk("ovfseq ovf@9", 32'(bus.overflow), 32'd1);
    chk("ovfseq full@9", 32'(bus.queue_full), 32'd1);
    drive(1'b1, 16'h3109, 8'h19, 1'b1);
    bus.overflow_clear = 1'b1;
    tick();
    chk("ovfseq set wins", 32'(bus.overflow), 32'd1);
    drive(1'b0, 16'h0, 8'h0, 1'b1);
    tick();
    chk("ovfseq clear", 32'(bus.overflow), 32'd0);
    bus.overflow_clear = 1'b0;
    drive(1'b0, 16'h0, 8'h0, 1'b0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.vram_we) begin
        if (n < 8) begin
          chk($sformatf("ovfseq addr%0d", n), 32'(bus.vram_address), 32'h100 + 32'(n));
          chk($sformatf("ovfseq data%0d", n), 32'(bus.vram_data), 32'h10 + 32'(n));
        end
        n++;
      end
    end
    chk("ovfseq strobes", 32'(n), 32'd8);
    chk("ovfseq empty", 32'(bus.queue_empty), 32'd1);

    // Full queue, write and permitted drain in the same cycle: nothing dropped.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h3200 + 16'(i), 8'h20 + 8'(i), 1'b1);
      tick();
    end
    chk("fulldrain full", 32'(bus.queue_full), 32'd1);
    drive(1'b1, 16'h3208, 8'h28, 1'b0);
    tick();
    chk("fulldrain we", 32'(bus.vram_we), 32'd1);
    chk("fulldrain addr", 32'(bus.vram_address), 32'h200);
    chk("fulldrain data", 32'(bus.vram_data), 32'h20);
    chk("fulldrain still full", 32'(bus.queue_full), 32'd1);
    chk("fulldrain ovf", 32'(bus.overflow), 32'd0);
    drive(1'b0, 16'h0, 8'h0, 1'b0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.vram_we) begin
        if (n < 8) begin
          chk($sformatf("fulldrain addr%0d", n), 32'(bus.vram_address), 32'h201 + 32'(n));
          chk($sformatf("fulldrain data%0d", n), 32'(bus.vram_data), 32'h21 + 32'(n));
        end
        n++;
      end
    end
    chk("fulldrain strobes", 32'(n), 32'd8);
    chk("fulldrain ovf end", 32'(bus.overflow), 32'd0);

    // Reset in the middle of a drain discards the rest of the queue.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h3300 + 16'(i), 8'h30 + 8'(i), 1'b1);
      tick();
    end
    drive(1'b0, 16'h0, 8'h0, 1'b0);
    tick();
    chk("rstdrain first we", 32'(bus.vram_we), 32'd1);
    chk("rstdrain first addr", 32'(bus.vram_address), 32'h300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstdrain we", 32'(bus.vram_we), 32'd0);
    chk("rstdrain empty", 32'(bus.queue_empty), 32'd1);
    chk("rstdrain full", 32'(bus.queue_full), 32'd0);
    chk("rstdrain addr", 32'(bus.vram_address), 32'h0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("rstdrain quiet%0d", c), 32'(bus.vram_we), 32'd0);
    end

`ifdef VRAM_WRITE_SCHEDULER_VBLANK_ONLY_EN
    // Drain held off outside vblank, then three back-to-back strobes.
    bus.vblank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h3400 + 16'(i), 8'h40 + 8'(i), 1'b0);
      tick();
      chk($sformatf("vblank hold%0d", i), 32'(bus.vram_we), 32'd0);
    end
    drive(1'b0, 16'h0, 8'h0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("vblank wait%0d", c), 32'(bus.vram_we), 32'd0);
    end
    bus.vblank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("vblank we%0d", i), 32'(bus.vram_we), 32'd1);
      chk($sformatf("vblank addr%0d", i), 32'(bus.vram_address), 32'h400 + 32'(i));
    end
    tick();
    chk("vblank done", 32'(bus.vram_we), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
